// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: fetch queue geometry, NOP encoding and
// the {pc, instr} entry type carried from fetch to decode.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          FETCH_Q_DEPTH    = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits carry no meaning.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between the instruction memory response and
// decode. Push and pop may coincide at any occupancy; flush empties it.
module fetch_queue
    import rv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    localparam logic [1:0] FULL = 2'(FETCH_Q_DEPTH);

    fetch_entry_t mem [FETCH_Q_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != FULL) || do_pop);
    end

    // NOTE: pointers and occupancy are control state and get the async reset;
    // the storage array is data qualified by count, so it is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != 2'd0);

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, credit-based request issue against a fixed
// 1-cycle instruction memory, in-flight tracking and branch/jump redirect.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic         drop;

    logic [1:0]   count;
    logic         q_valid;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    logic         pop;
    logic         push;
    logic         resp;
    logic         issue;
    logic [2:0]   credit_used;

    // A slot is reserved for every queued word and every outstanding request,
    // so a response can always be accepted without back-pressure.
    always_comb begin
        pop         = q_valid && id_ready;
        credit_used = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
        issue       = rst_n && !redirect_valid && (credit_used < 3'd2);
        resp        = imem_rvalid && inflight;
        push        = resp && !drop && !redirect_valid;
        push_entry  = '{pc: inflight_pc, instr: imem_rdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            drop        <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= word_align(redirect_pc);
            // A word arriving now is discarded by the flush; only a response
            // still to come must be marked stale.
            inflight <= inflight && !imem_rvalid;
            drop     <= inflight && !imem_rvalid;
        end else begin
            if (issue) begin
                pc          <= pc + 32'd4;
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else if (resp) begin
                inflight <= 1'b0;
            end
            if (resp && drop) drop <= 1'b0;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .valid      (q_valid),
        .count      (count)
    );

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign if_valid  = q_valid;
    assign if_instr  = q_valid ? head.instr : NOP_INSTR;
    assign if_pc     = q_valid ? head.pc : 32'h0000_0000;

endmodule
